wheel_sync: RTL and testbench

//  Sounding-trigger source feeding stick_main. Decodes the wheel quadrature

---
 rtl/stick_pkg.sv | 48 ++++
 rtl/sig_filter.sv | 55 +++++
 rtl/wheel_sync.sv | 203 ++++++++++++++++++++
 tb/tb_wheel_sync.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stick_pkg.sv
// Shared constants and quadrature helpers for the wheel sounding-trigger path.
package stick_pkg;

  localparam logic SRC_WHEEL        = 1'b0;
  localparam logic SRC_EXT          = 1'b1;
  localparam int   FILT_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_11 = 2'b11,
    QS_10 = 2'b10
  } quad_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BWD  = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  // Position of an {A,B} level pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] ph;
    case (quad_state_e'(ab))
      QS_00:   ph = 2'd0;
      QS_01:   ph = 2'd1;
      QS_11:   ph = 2'd2;
      QS_10:   ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

  function automatic step_e quad_step(input logic [1:0] ab_old, input logic [1:0] ab_new);
    logic [1:0] diff;
    step_e      s;
    diff = quad_phase(ab_new) - quad_phase(ab_old);
    case (diff)
      2'd1:    s = STEP_FWD;
      2'd3:    s = STEP_BWD;
      2'd2:    s = STEP_ILL;
      default: s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sig_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output follows the
// input only after FILT_LEN consecutive equal synchronized samples.
module sig_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Run-length count of samples that disagree with the filtered level.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = {CNT_W{1'b0}};
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Synchronizer, filter level and counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/wheel_sync.sv
// Wheel quadrature decoder with backlash-suppressed divider producing sounding
// triggers, or pass-through of the filtered external sync, plus status outputs.
module wheel_sync
  import stick_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEFAULT,
  parameter int POS_W    = 32,
  parameter int DIV_W    = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             adp,
  input  logic             bdp,
  input  logic             sync_ext,
  input  logic             cfg_src,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_dir_inv,
  input  logic             pos_clr,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             step_stb,
  output logic             sync_pulse,
  output logic [DIV_W-1:0] sync_cnt,
  output logic             err_illegal,
  output logic             err_flag
);

  logic a_filt, b_filt, ext_filt;

  sig_filter #(.FILT_LEN(FILT_LEN)) u_filt_a   (.clk(sys_clk), .reset(reset), .din(adp),      .dout(a_filt));
  sig_filter #(.FILT_LEN(FILT_LEN)) u_filt_b   (.clk(sys_clk), .reset(reset), .din(bdp),      .dout(b_filt));
  sig_filter #(.FILT_LEN(FILT_LEN)) u_filt_ext (.clk(sys_clk), .reset(reset), .din(sync_ext), .dout(ext_filt));

  logic [1:0]       ab_now;
  logic [1:0]       ab_prev_q, ab_prev_d;
  logic             init_q, init_d;
  step_e            dec_q, dec_d;
  logic             ext_prev_q, ext_prev_d;
  logic             ext_rise_q, ext_rise_d;
  logic             up_q, up_d, dn_q, dn_d, ill_q, ill_d;
  logic             ext_fire_q, ext_fire_d;
  logic [DIV_W-1:0] cfg_div_q, cfg_div_d;
  logic             cfg_src_q, cfg_src_d;
  logic [POS_W-1:0] pos_q, pos_d, pos_max_q, pos_max_d, pos_step;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, sync_cnt_q, sync_cnt_d;
  logic             qualify, cfg_chg, wheel_on, wheel_fire;
  logic             dir_q, dir_d, step_stb_q, step_stb_d, sync_pulse_q, sync_pulse_d;
  logic             err_illegal_q, err_illegal_d, err_flag_q, err_flag_d;

  assign ab_now = {a_filt, b_filt};

  // Decode stage: the first filtered change after reset only seeds ab_prev.
  always_comb begin
    ab_prev_d  = ab_prev_q;
    init_d     = init_q;
    dec_d      = STEP_NONE;
    ext_prev_d = ext_filt;
    ext_rise_d = ext_filt & ~ext_prev_q;
    if (ab_now != ab_prev_q) begin
      ab_prev_d = ab_now;
      if (init_q) begin
        init_d = 1'b0;
      end else begin
        dec_d = quad_step(ab_prev_q, ab_now);
      end
    end else begin
      ab_prev_d = ab_prev_q;
    end
  end

  // Direction stage: apply counting inversion.
  always_comb begin
    up_d       = 1'b0;
    dn_d       = 1'b0;
    ill_d      = 1'b0;
    ext_fire_d = ext_rise_q;
    case (dec_q)
      STEP_FWD: begin
        up_d = ~cfg_dir_inv;
        dn_d = cfg_dir_inv;
      end
      STEP_BWD: begin
        up_d = cfg_dir_inv;
        dn_d = ~cfg_dir_inv;
      end
      STEP_ILL: ill_d = 1'b1;
      default:  ill_d = 1'b0;
    endcase
  end

  // Position and backlash tracking; pos_clr discards a coincident step.
  always_comb begin
    cfg_div_d  = cfg_div;
    cfg_src_d  = cfg_src;
    pos_step   = up_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
    qualify    = up_q && ($signed(pos_step) > $signed(pos_max_q));
    cfg_chg    = (cfg_div != cfg_div_q) || (cfg_src != cfg_src_q);
    wheel_on   = (cfg_src_q == SRC_WHEEL) && (cfg_div_q != {DIV_W{1'b0}});
    pos_d      = pos_q;
    pos_max_d  = pos_max_q;
    dir_d      = dir_q;
    step_stb_d = 1'b0;
    if (pos_clr) begin
      pos_d     = {POS_W{1'b0}};
      pos_max_d = {POS_W{1'b0}};
    end else if (up_q || dn_q) begin
      pos_d      = pos_step;
      dir_d      = up_q;
      step_stb_d = 1'b1;
      pos_max_d  = qualify ? pos_step : pos_max_q;
    end else begin
      pos_d = pos_q;
    end
  end

  // Divider: counts only fresh forward path, restarts on any config change.
  always_comb begin
    wheel_fire = 1'b0;
    if (pos_clr || cfg_chg) begin
      div_cnt_d = {DIV_W{1'b0}};
    end else if (qualify && wheel_on) begin
      if (div_cnt_q == (cfg_div_q - DIV_W'(1))) begin
        wheel_fire = 1'b1;
        div_cnt_d  = {DIV_W{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Strobe, counter and error status; a new error beats err_clr.
  always_comb begin
    sync_pulse_d  = wheel_fire | ((cfg_src_q == SRC_EXT) & ext_fire_q);
    sync_cnt_d    = sync_cnt_q + {{(DIV_W-1){1'b0}}, sync_pulse_d};
    err_illegal_d = ill_q;
    if (ill_q) begin
      err_flag_d = 1'b1;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // All pipeline and output registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      ab_prev_q     <= 2'b00;
      init_q        <= 1'b1;
      dec_q         <= STEP_NONE;
      ext_prev_q    <= 1'b0;
      ext_rise_q    <= 1'b0;
      up_q          <= 1'b0;
      dn_q          <= 1'b0;
      ill_q         <= 1'b0;
      ext_fire_q    <= 1'b0;
      cfg_div_q     <= {DIV_W{1'b0}};
      cfg_src_q     <= 1'b0;
      pos_q         <= {POS_W{1'b0}};
      pos_max_q     <= {POS_W{1'b0}};
      div_cnt_q     <= {DIV_W{1'b0}};
      sync_cnt_q    <= {DIV_W{1'b0}};
      dir_q         <= 1'b0;
      step_stb_q    <= 1'b0;
      sync_pulse_q  <= 1'b0;
      err_illegal_q <= 1'b0;
      err_flag_q    <= 1'b0;
    end else begin
      ab_prev_q     <= ab_prev_d;
      init_q        <= init_d;
      dec_q         <= dec_d;
      ext_prev_q    <= ext_prev_d;
      ext_rise_q    <= ext_rise_d;
      up_q          <= up_d;
      dn_q          <= dn_d;
      ill_q         <= ill_d;
      ext_fire_q    <= ext_fire_d;
      cfg_div_q     <= cfg_div_d;
      cfg_src_q     <= cfg_src_d;
      pos_q         <= pos_d;
      pos_max_q     <= pos_max_d;
      div_cnt_q     <= div_cnt_d;
      sync_cnt_q    <= sync_cnt_d;
      dir_q         <= dir_d;
      step_stb_q    <= step_stb_d;
      sync_pulse_q  <= sync_pulse_d;
      err_illegal_q <= err_illegal_d;
      err_flag_q    <= err_flag_d;
    end
  end

  assign pos         = pos_q;
  assign dir         = dir_q;
  assign step_stb    = step_stb_q;
  assign sync_pulse  = sync_pulse_q;
  assign sync_cnt    = sync_cnt_q;
  assign err_illegal = err_illegal_q;
  assign err_flag    = err_flag_q;

endmodule

// File: tb/tb_wheel_sync.sv
// Self-checking bench for wheel_sync: randomized wheel motion against a
// step-level reference model, with strobe timing checked cycle-exactly.
`timescale 1ns/1ps
module tb_wheel_sync;

  localparam int FILT_LEN = 8;
  localparam int POS_W    = 32;
  localparam int DIV_W    = 16;
  // Output visible at the negedge LAT cycles after the negedge that drove the pin.
  localparam int LAT      = FILT_LEN + 5;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b1;
  logic             adp = 1'b0, bdp = 1'b0, sync_ext = 1'b0, cfg_src = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_dir_inv = 1'b0, pos_clr = 1'b0, err_clr = 1'b0;
  logic [POS_W-1:0] pos;
  logic             dir, step_stb, sync_pulse, err_illegal, err_flag;
  logic [DIV_W-1:0] sync_cnt;

  wheel_sync #(.FILT_LEN(FILT_LEN), .POS_W(POS_W), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk), .reset(reset), .adp(adp), .bdp(bdp), .sync_ext(sync_ext),
    .cfg_src(cfg_src), .cfg_div(cfg_div), .cfg_dir_inv(cfg_dir_inv),
    .pos_clr(pos_clr), .err_clr(err_clr), .pos(pos), .dir(dir),
    .step_stb(step_stb), .sync_pulse(sync_pulse), .sync_cnt(sync_cnt),
    .err_illegal(err_illegal), .err_flag(err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int unsigned act_sync[$], act_step[$], act_ill[$];
  int unsigned exp_sync[$], exp_step[$], exp_ill[$];

  always @(negedge sys_clk) begin
    if (sync_pulse === 1'b1)  act_sync.push_back(cyc);
    if (step_stb === 1'b1)    act_step.push_back(cyc);
    if (err_illegal === 1'b1) act_ill.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: physical wheel phase and the logical counters.
  logic [1:0]  gray [4];
  int          m_phase, m_pos, m_max, m_cnt, m_div;
  bit          m_src, m_inv, m_flag, m_dir;
  int unsigned m_scnt;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_q();
    act_sync.delete(); act_step.delete(); act_ill.delete();
    exp_sync.delete(); exp_step.delete(); exp_ill.delete();
  endtask

  // kind: +1 forward, -1 backward, 2 illegal; dc = cycle the pins were driven.
  task automatic model_event(input int kind, input int unsigned dc);
    int d;
    int unsigned t;
    t = dc + LAT;
    if (kind == 2) begin
      exp_ill.push_back(t);
      m_flag = 1'b1;
    end else begin
      d = m_inv ? -kind : kind;
      m_pos = m_pos + d;
      m_dir = (d > 0);
      exp_step.push_back(t);
      if (d > 0 && m_pos > m_max) begin
        m_max = m_pos;
        if (!m_src && m_div != 0) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == m_div) begin
            m_cnt = 0;
            exp_sync.push_back(t);
            m_scnt = m_scnt + 1;
          end
        end
      end
    end
  endtask

  task automatic drive_step(input bit fwd, input int hold);
    @(negedge sys_clk);
    m_phase = fwd ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
    {adp, bdp} = gray[m_phase];
    model_event(fwd ? 1 : -1, cyc);
    tick(hold - 1);
  endtask

  task automatic set_div(input int v);
    @(negedge sys_clk);
    cfg_div = DIV_W'(v);
    m_div = v;
    m_cnt = 0;
    tick(2);
  endtask

  task automatic test_reset();
    adp = 1'b1; bdp = 1'b1; reset = 1'b1;
    tick(4);
    n_cmp++;
    if ({pos, dir, step_stb, sync_pulse, sync_cnt, err_illegal, err_flag} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got pos=%0h dir=%0b stb=%0b sp=%0b cnt=%0d ill=%0b flag=%0b, want all 0",
               pos, dir, step_stb, sync_pulse, sync_cnt, err_illegal, err_flag);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    m_phase = 2; m_pos = 0; m_max = 0; m_cnt = 0; m_div = 0;
    m_src = 1'b0; m_inv = 1'b0; m_flag = 1'b0; m_dir = 1'b0; m_scnt = 0;
    clear_q();
    tick(20);
    n_cmp++;
    if (act_step.size() !== 0) begin
      n_bad++; $display("FAIL reset_no_step: got %0d steps, want 0", act_step.size());
    end
    n_cmp++;
    if (act_ill.size() !== 0) begin
      n_bad++; $display("FAIL reset_no_illegal: got %0d, want 0", act_ill.size());
    end
    n_cmp++;
    if (pos !== '0) begin
      n_bad++; $display("FAIL reset_pos: got %0d, want 0", $signed(pos));
    end
  endtask

  task automatic test_forward();
    clear_q();
    set_div(4);
    for (int i = 0; i < 16; i++) drive_step(1'b1, 20);
    tick(25);
    n_cmp++;
    if (act_sync.size() !== exp_sync.size()) begin
      n_bad++; $display("FAIL fwd_sync_count: got %0d, want %0d", act_sync.size(), exp_sync.size());
    end
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++) begin
      n_cmp++;
      if (act_sync[i] !== exp_sync[i]) begin
        n_bad++; $display("FAIL fwd_sync_time[%0d]: got cycle %0d, want %0d", i, act_sync[i], exp_sync[i]);
      end
    end
    n_cmp++;
    if (act_step.size() !== exp_step.size()) begin
      n_bad++; $display("FAIL fwd_step_count: got %0d, want %0d", act_step.size(), exp_step.size());
    end
    for (int i = 0; i < exp_step.size() && i < act_step.size(); i++) begin
      n_cmp++;
      if (act_step[i] !== exp_step[i]) begin
        n_bad++; $display("FAIL fwd_step_time[%0d]: got cycle %0d, want %0d", i, act_step[i], exp_step[i]);
      end
    end
    n_cmp++;
    if (pos !== POS_W'(m_pos)) begin
      n_bad++; $display("FAIL fwd_pos: got %0d, want %0d", $signed(pos), m_pos);
    end
    n_cmp++;
    if (sync_cnt !== DIV_W'(m_scnt)) begin
      n_bad++; $display("FAIL fwd_sync_cnt: got %0d, want %0d", sync_cnt, m_scnt);
    end
    n_cmp++;
    if (dir !== m_dir) begin
      n_bad++; $display("FAIL fwd_dir: got %0b, want %0b", dir, m_dir);
    end
  endtask

  task automatic test_backlash();
    set_div(2);
    @(negedge sys_clk); pos_clr = 1'b1;
    @(negedge sys_clk); pos_clr = 1'b0;
    m_pos = 0; m_max = 0; m_cnt = 0;
    tick(2);
    clear_q();
    for (int i = 0; i < 8; i++) drive_step(1'b1, $urandom_range(12, 24));
    for (int i = 0; i < 4; i++) drive_step(1'b0, $urandom_range(12, 24));
    for (int i = 0; i < 8; i++) drive_step(1'b1, $urandom_range(12, 24));
    tick(25);
    n_cmp++;
    if (act_sync.size() !== exp_sync.size()) begin
      n_bad++; $display("FAIL backlash_sync_count: got %0d, want %0d", act_sync.size(), exp_sync.size());
    end
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++) begin
      n_cmp++;
      if (act_sync[i] !== exp_sync[i]) begin
        n_bad++; $display("FAIL backlash_sync_time[%0d]: got cycle %0d, want %0d", i, act_sync[i], exp_sync[i]);
      end
    end
    n_cmp++;
    if (pos !== POS_W'(m_pos)) begin
      n_bad++; $display("FAIL backlash_pos: got %0d, want %0d", $signed(pos), m_pos);
    end
    n_cmp++;
    if (act_step.size() !== exp_step.size()) begin
      n_bad++; $display("FAIL backlash_step_count: got %0d, want %0d", act_step.size(), exp_step.size());
    end
  endtask

  task automatic test_glitch_illegal();
    clear_q();
    @(negedge sys_clk); adp = ~adp;
    tick(5);
    adp = ~adp;
    tick(25);
    n_cmp++;
    if (act_step.size() !== 0) begin
      n_bad++; $display("FAIL glitch_no_step: got %0d steps, want 0", act_step.size());
    end
    @(negedge sys_clk);
    m_phase = (m_phase + 2) % 4;
    {adp, bdp} = gray[m_phase];
    model_event(2, cyc);
    tick(25);
    n_cmp++;
    if (act_ill.size() !== exp_ill.size()) begin
      n_bad++; $display("FAIL illegal_count: got %0d, want %0d", act_ill.size(), exp_ill.size());
    end
    for (int i = 0; i < exp_ill.size() && i < act_ill.size(); i++) begin
      n_cmp++;
      if (act_ill[i] !== exp_ill[i]) begin
        n_bad++; $display("FAIL illegal_time[%0d]: got cycle %0d, want %0d", i, act_ill[i], exp_ill[i]);
      end
    end
    n_cmp++;
    if (err_flag !== m_flag) begin
      n_bad++; $display("FAIL illegal_flag: got %0b, want %0b", err_flag, m_flag);
    end
    n_cmp++;
    if (pos !== POS_W'(m_pos) || act_step.size() !== 0) begin
      n_bad++; $display("FAIL illegal_pos: got %0d (%0d steps), want %0d (0 steps)", $signed(pos), act_step.size(), m_pos);
    end
    @(negedge sys_clk); err_clr = 1'b1;
    @(negedge sys_clk); err_clr = 1'b0;
    m_flag = 1'b0;
    tick(1);
    n_cmp++;
    if (err_flag !== m_flag) begin
      n_bad++; $display("FAIL err_clr: got %0b, want %0b", err_flag, m_flag);
    end
  endtask

  task automatic test_external();
    clear_q();
    @(negedge sys_clk); cfg_src = 1'b1;
    m_src = 1'b1; m_cnt = 0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk); sync_ext = 1'b1;
      exp_sync.push_back(cyc + LAT);
      m_scnt = m_scnt + 1;
      tick($urandom_range(10, 16));
      sync_ext = 1'b0;
      tick($urandom_range(10, 16));
    end
    for (int i = 0; i < 4; i++) drive_step(1'b1, $urandom_range(12, 20));
    tick(25);
    n_cmp++;
    if (act_sync.size() !== exp_sync.size()) begin
      n_bad++; $display("FAIL ext_sync_count: got %0d, want %0d", act_sync.size(), exp_sync.size());
    end
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++) begin
      n_cmp++;
      if (act_sync[i] !== exp_sync[i]) begin
        n_bad++; $display("FAIL ext_sync_time[%0d]: got cycle %0d, want %0d", i, act_sync[i], exp_sync[i]);
      end
    end
    n_cmp++;
    if (pos !== POS_W'(m_pos) || act_step.size() !== exp_step.size()) begin
      n_bad++; $display("FAIL ext_pos: got %0d (%0d steps), want %0d (%0d steps)",
                        $signed(pos), act_step.size(), m_pos, exp_step.size());
    end
    n_cmp++;
    if (sync_cnt !== DIV_W'(m_scnt)) begin
      n_bad++; $display("FAIL ext_sync_cnt: got %0d, want %0d", sync_cnt, m_scnt);
    end
    // pos_clr lands in the same cycle the step would update pos.
    clear_q();
    @(negedge sys_clk);
    m_phase = (m_phase + 1) % 4;
    {adp, bdp} = gray[m_phase];
    tick(LAT - 1);
    pos_clr = 1'b1;
    @(negedge sys_clk); pos_clr = 1'b0;
    m_pos = 0; m_max = 0; m_cnt = 0;
    tick(20);
    n_cmp++;
    if (pos !== POS_W'(m_pos)) begin
      n_bad++; $display("FAIL posclr_with_step: got %0d, want %0d", $signed(pos), m_pos);
    end
    @(negedge sys_clk); cfg_src = 1'b0;
    m_src = 1'b0; m_cnt = 0;
    tick(2);
  endtask

  task automatic test_config();
    clear_q();
    set_div(0);
    for (int i = 0; i < int'($urandom_range(3, 6)); i++) drive_step(1'b1, 16);
    set_div(3);
    for (int i = 0; i < 2; i++) drive_step(1'b1, 16);
    set_div(4);
    for (int i = 0; i < 4; i++) drive_step(1'b1, 16);
    tick(25);
    n_cmp++;
    if (act_sync.size() !== exp_sync.size()) begin
      n_bad++; $display("FAIL cfg_sync_count: got %0d, want %0d", act_sync.size(), exp_sync.size());
    end
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++) begin
      n_cmp++;
      if (act_sync[i] !== exp_sync[i]) begin
        n_bad++; $display("FAIL cfg_sync_time[%0d]: got cycle %0d, want %0d", i, act_sync[i], exp_sync[i]);
      end
    end
    clear_q();
    @(negedge sys_clk); cfg_dir_inv = 1'b1; m_inv = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) drive_step(1'b1, $urandom_range(12, 20));
    tick(25);
    n_cmp++;
    if (pos !== POS_W'(m_pos)) begin
      n_bad++; $display("FAIL inv_pos: got %0d, want %0d", $signed(pos), m_pos);
    end
    n_cmp++;
    if (dir !== m_dir || act_sync.size() !== 0) begin
      n_bad++; $display("FAIL inv_dir: got dir=%0b strobes=%0d, want dir=%0b strobes=0", dir, act_sync.size(), m_dir);
    end
    @(negedge sys_clk); cfg_dir_inv = 1'b0; m_inv = 1'b0;
    tick(2);
  endtask

  task automatic test_random_walk();
    clear_q();
    set_div($urandom_range(1, 5));
    for (int i = 0; i < 40; i++) drive_step($urandom_range(0, 9) < 7, $urandom_range(10, 24));
    tick(25);
    n_cmp++;
    if (act_sync.size() !== exp_sync.size()) begin
      n_bad++; $display("FAIL walk_sync_count: got %0d, want %0d (div %0d)", act_sync.size(), exp_sync.size(), m_div);
    end
    for (int i = 0; i < exp_sync.size() && i < act_sync.size(); i++) begin
      n_cmp++;
      if (act_sync[i] !== exp_sync[i]) begin
        n_bad++; $display("FAIL walk_sync_time[%0d]: got cycle %0d, want %0d", i, act_sync[i], exp_sync[i]);
      end
    end
    n_cmp++;
    if (act_step.size() !== exp_step.size()) begin
      n_bad++; $display("FAIL walk_step_count: got %0d, want %0d", act_step.size(), exp_step.size());
    end
    n_cmp++;
    if (pos !== POS_W'(m_pos) || dir !== m_dir) begin
      n_bad++; $display("FAIL walk_pos_dir: got %0d/%0b, want %0d/%0b", $signed(pos), dir, m_pos, m_dir);
    end
    n_cmp++;
    if (sync_cnt !== DIV_W'(m_scnt)) begin
      n_bad++; $display("FAIL walk_sync_cnt: got %0d, want %0d", sync_cnt, m_scnt);
    end
  endtask

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    test_reset();
    test_forward();
    test_backlash();
    test_glitch_illegal();
    test_external();
    test_config();
    test_random_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
